av_menu_overlay: RTL and testbench

Parametrised successor to the fixed-rectangle menu layer. Draws a configurable menu panel with NUM_ITEMS selectable rows, a highlight bar driven by button pulses, and a per-frame fade-in/fade-out. Output feeds the pixel mixer as {valid, 12-bit RGB}, in the same format as the other overlay layers. Runs in the 65 MHz pixel domain.

---
 rtl/av_pkg.sv | 27 ++
 rtl/av_color_scale.sv | 28 ++
 rtl/av_menu_overlay.sv | 232 +++++++++++++++++++++++
 tb/tb_av_menu_overlay.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/av_pkg.sv
// rtl/av_pkg.sv - shared types and pixel-format constants for the AV overlay layers
//
// Contents:
//   fade_state_t    : fade FSM states used by fading overlays
//   CH_W/RGB_W      : RGB444 channel and pixel widths
//   overlay_pixel_t : 13-bit {valid, RGB444} word consumed by the pixel mixer
package av_pkg;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    localparam int CH_W  = 4;
    localparam int RGB_W = 3 * CH_W;
    localparam int PIX_W = RGB_W + 1;

    typedef struct packed {
        logic             valid;
        logic [RGB_W-1:0] rgb;
    } overlay_pixel_t;

    localparam overlay_pixel_t PIX_BLANK = '{valid: 1'b0, rgb: '0};

endpackage

// File: rtl/av_color_scale.sv
// rtl/av_color_scale.sv - combinational RGB444 x fade-level brightness scaler
//
// Ports:
//   rgb    in  RGB_W  unscaled RGB444 colour
//   level  in  LVL_W  brightness, 0..FADE_MAX (FADE_MAX = full brightness)
//   scaled out RGB_W  each channel = (ch * level) >> log2(FADE_MAX)
module av_color_scale
    import av_pkg::*;
#(
    parameter int FADE_MAX = 16,
    parameter int LVL_W    = $clog2(FADE_MAX) + 1
) (
    input  logic [RGB_W-1:0] rgb,
    input  logic [LVL_W-1:0] level,
    output logic [RGB_W-1:0] scaled
);

    localparam int SHIFT  = $clog2(FADE_MAX);
    // One spare bit above ch*FADE_MAX so the full-brightness product never overflows.
    localparam int PROD_W = CH_W + SHIFT + 1;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [PROD_W-1:0] prod;
        assign prod = PROD_W'(rgb[c*CH_W +: CH_W]) * PROD_W'(level);
        assign scaled[c*CH_W +: CH_W] = CH_W'(prod >> SHIFT);
    end

endmodule

// File: rtl/av_menu_overlay.sv
// rtl/av_menu_overlay.sv - fading menu panel overlay with highlight-bar row selection
//
// Ports:
//   clk65      in   1       pixel clock
//   reset      in   1       asynchronous active-high reset
//   frame_tick in   1       one pulse per frame; all fade changes happen here
//   show       in   1       level request to display the menu
//   btn_up     in   1       move highlight up (wraps), only while fully shown
//   btn_down   in   1       move highlight down (wraps), only while fully shown
//   btn_select in   1       choose highlighted row, only while fully shown
//   hcount     in   11      pixel column
//   vcount     in   10      pixel row
//   menu_pixel out  13      {valid, RGB444}, 2 cycles after hcount/vcount
//   sel_index  out  SEL_W   highlighted row
//   sel_strobe out  1       one-cycle pulse: row sel_index chosen
//   fade_level out  LVL_W   current brightness 0..FADE_MAX
module av_menu_overlay
    import av_pkg::*;
#(
    parameter int          START_X     = 100,
    parameter int          START_Y     = 50,
    parameter int          WIDTH       = 800,
    parameter int          HEIGHT      = 600,
    parameter logic [11:0] BG_COLOR    = 12'hDDD,
    parameter logic [11:0] HI_COLOR    = 12'h44F,
    parameter int          NUM_ITEMS   = 4,
    parameter int          ITEM_Y0     = 100,
    parameter int          ITEM_H      = 100,
    parameter int          ITEM_MARGIN = 50,
    parameter int          FADE_MAX    = 16,
    parameter int          SEL_W       = $clog2(NUM_ITEMS),
    parameter int          LVL_W       = $clog2(FADE_MAX) + 1
) (
    input  logic             clk65,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             show,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_select,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    output logic [12:0]      menu_pixel,
    output logic [SEL_W-1:0] sel_index,
    output logic             sel_strobe,
    output logic [LVL_W-1:0] fade_level
);

    localparam logic [10:0] X_LO  = 11'(START_X);
    localparam logic [10:0] X_HI  = 11'(START_X + WIDTH);
    localparam logic [10:0] BX_LO = 11'(START_X + ITEM_MARGIN);
    localparam logic [10:0] BX_HI = 11'(START_X + WIDTH - ITEM_MARGIN);
    localparam logic [10:0] Y_LO  = 11'(START_Y);
    localparam logic [10:0] Y_HI  = 11'(START_Y + HEIGHT);
    localparam logic [10:0] ROW_H = 11'(ITEM_H);

    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FADE_MAX);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ITEMS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    // ---------------------------------------------------------------
    // Fade FSM: state and level only move on frame_tick
    // ---------------------------------------------------------------
    fade_state_t      state, state_next;
    logic [LVL_W-1:0] level, level_next;

    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            state <= HIDDEN;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    always_comb begin
        state_next = state;
        level_next = level;
        if (frame_tick) begin
            case (state)
                HIDDEN: begin
                    if (show) begin
                        state_next = FADE_IN;
                        level_next = LVL_ONE;
                    end
                end
                FADE_IN: begin
                    // Losing show freezes the level for this tick; decay starts next tick.
                    if (!show) begin
                        state_next = FADE_OUT;
                    end else if (level >= LVL_MAX - LVL_ONE) begin
                        state_next = SHOWN;
                        level_next = LVL_MAX;
                    end else begin
                        level_next = level + LVL_ONE;
                    end
                end
                SHOWN: begin
                    if (!show) begin
                        state_next = FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (show) begin
                        state_next = FADE_IN;
                    end else if (level <= LVL_ONE) begin
                        state_next = HIDDEN;
                        level_next = '0;
                    end else begin
                        level_next = level - LVL_ONE;
                    end
                end
                default: begin
                    state_next = HIDDEN;
                    level_next = '0;
                end
            endcase
        end
    end

    assign fade_level = level;

    // ---------------------------------------------------------------
    // Row selection: buttons are only honoured once fully shown.
    // Select beats a simultaneous move; up+down together cancel.
    // ---------------------------------------------------------------
    logic [SEL_W-1:0] sel_q;
    logic             strobe_q;

    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            sel_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (state == SHOWN) begin
                if (btn_select) begin
                    strobe_q <= 1'b1;
                end else if (btn_up && !btn_down) begin
                    sel_q <= (sel_q == '0) ? SEL_LAST : sel_q - SEL_ONE;
                end else if (btn_down && !btn_up) begin
                    sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_ONE;
                end
            end
        end
    end

    assign sel_index  = sel_q;
    assign sel_strobe = strobe_q;

    // ---------------------------------------------------------------
    // Highlighted row bounds: a constant table indexed by sel_index,
    // so no runtime multiplier is needed.
    // ---------------------------------------------------------------
    logic [10:0] row_top;
    logic [10:0] row_bot;

    always_comb begin
        row_top = 11'(START_Y + ITEM_Y0);
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                row_top = 11'(START_Y + ITEM_Y0 + i * ITEM_H);
            end
        end
    end

    assign row_bot = row_top + ROW_H;

    // ---------------------------------------------------------------
    // Pixel pipeline stage 1: region classification
    // ---------------------------------------------------------------
    logic [10:0] v_ext;
    logic        in_panel_c, in_bar_c;
    logic        in_panel_q, in_bar_q;

    assign v_ext      = {1'b0, vcount};
    assign in_panel_c = (hcount >= X_LO) && (hcount < X_HI) &&
                        (v_ext >= Y_LO) && (v_ext < Y_HI);
    assign in_bar_c   = in_panel_c &&
                        (hcount >= BX_LO) && (hcount < BX_HI) &&
                        (v_ext >= row_top) && (v_ext < row_bot);

    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            in_panel_q <= 1'b0;
            in_bar_q   <= 1'b0;
        end else begin
            in_panel_q <= in_panel_c;
            in_bar_q   <= in_bar_c;
        end
    end

    // ---------------------------------------------------------------
    // Pixel pipeline stage 2: colour pick, fade scaling, valid gating
    // ---------------------------------------------------------------
    logic [RGB_W-1:0] base_rgb;
    logic [RGB_W-1:0] scaled_rgb;
    overlay_pixel_t   pix_next;
    overlay_pixel_t   pix_q;

    assign base_rgb = in_bar_q ? HI_COLOR : BG_COLOR;

    av_color_scale #(
        .FADE_MAX (FADE_MAX),
        .LVL_W    (LVL_W)
    ) u_scale (
        .rgb    (base_rgb),
        .level  (level),
        .scaled (scaled_rgb)
    );

    always_comb begin
        pix_next = PIX_BLANK;
        if (in_panel_q && (level != '0)) begin
            pix_next.valid = 1'b1;
            pix_next.rgb   = scaled_rgb;
        end
    end

    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            pix_q <= PIX_BLANK;
        end else begin
            pix_q <= pix_next;
        end
    end

    assign menu_pixel = pix_q;

endmodule

// File: tb/tb_av_menu_overlay.sv
// tb/tb_av_menu_overlay.sv - self-checking bench for av_menu_overlay
module tb_av_menu_overlay;

    localparam int PX0 = 100, PY0 = 50, PW = 800, PH = 600;
    localparam int IY0 = 100, IH = 100, IM = 50, NI = 4, FMAX = 16;
    localparam int BG = 'hDDD, HI = 'h44F;

    localparam int M_HID = 0, M_IN = 1, M_SHOWN = 2, M_OUT = 3;

    logic        clk65 = 1'b0;
    logic        reset, frame_tick, show, btn_up, btn_down, btn_select;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [12:0] menu_pixel;
    logic [1:0]  sel_index;
    logic        sel_strobe;
    logic [4:0]  fade_level;

    av_menu_overlay dut (
        .clk65      (clk65),
        .reset      (reset),
        .frame_tick (frame_tick),
        .show       (show),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_select (btn_select),
        .hcount     (hcount),
        .vcount     (vcount),
        .menu_pixel (menu_pixel),
        .sel_index  (sel_index),
        .sel_strobe (sel_strobe),
        .fade_level (fade_level)
    );

    always #5 clk65 = ~clk65;

    int n_checks = 0;
    int n_errors = 0;

    int m_level = 0;
    int m_mode  = M_HID;
    int m_sel   = 0;
    int m_strobe = 0;

    typedef struct {
        int    h;
        int    v;
        int    exp;
        string name;
    } pix_vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pixel(input int h, input int v, input int sel, input int lvl);
        int col, r, g, b;
        bit panel, bar;
        panel = (h >= PX0) && (h < PX0 + PW) && (v >= PY0) && (v < PY0 + PH);
        bar   = panel && (h >= PX0 + IM) && (h < PX0 + PW - IM) &&
                (v >= PY0 + IY0 + sel * IH) && (v < PY0 + IY0 + (sel + 1) * IH);
        if (!panel || lvl == 0) return 0;
        col = bar ? HI : BG;
        r = ((col / 256) % 16) * lvl / FMAX;
        g = ((col / 16) % 16) * lvl / FMAX;
        b = (col % 16) * lvl / FMAX;
        return 4096 + r * 256 + g * 16 + b;
    endfunction

    // Advance the reference by one clock using the inputs present before the edge.
    task automatic model_edge();
        int nxt_strobe;
        if (reset) begin
            m_level = 0; m_mode = M_HID; m_sel = 0; m_strobe = 0;
            return;
        end
        nxt_strobe = 0;
        if (m_mode == M_SHOWN) begin
            if (btn_select) nxt_strobe = 1;
            else if (btn_up && !btn_down) m_sel = (m_sel + NI - 1) % NI;
            else if (btn_down && !btn_up) m_sel = (m_sel + 1) % NI;
        end
        m_strobe = nxt_strobe;
        if (frame_tick) begin
            case (m_mode)
                M_HID: if (show) begin m_mode = M_IN; m_level = 1; end
                M_IN: begin
                    if (!show) m_mode = M_OUT;
                    else begin
                        m_level = (m_level + 1 > FMAX) ? FMAX : m_level + 1;
                        if (m_level == FMAX) m_mode = M_SHOWN;
                    end
                end
                M_SHOWN: if (!show) m_mode = M_OUT;
                default: begin
                    if (show) m_mode = M_IN;
                    else begin
                        m_level = (m_level > 0) ? m_level - 1 : 0;
                        if (m_level == 0) m_mode = M_HID;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk65);
        #1;
        chk("fade_level", int'(fade_level), m_level);
        chk("sel_index", int'(sel_index), m_sel);
        chk("sel_strobe", int'(sel_strobe), m_strobe);
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        cycle();
    endtask

    task automatic press(input bit up, input bit down, input bit sel);
        btn_up = up; btn_down = down; btn_select = sel;
        cycle();
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
        cycle();
    endtask

    task automatic pixel_at(input int h, input int v, input string name, input int exp);
        hcount = 11'(h);
        vcount = 10'(v);
        repeat (3) cycle();
        chk(name, int'(menu_pixel), exp);
    endtask

    pix_vec_t vecs[$];

    initial begin
        reset = 1'b1; frame_tick = 1'b0; show = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
        hcount = '0; vcount = '0;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_pixel", int'(menu_pixel), 0);
        chk("rst_sel", int'(sel_index), 0);
        chk("rst_strobe", int'(sel_strobe), 0);
        chk("rst_level", int'(fade_level), 0);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // Fade in: one level step per tick; buttons ignored while fading.
        show = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            do_tick();
            chk("fadein_level", int'(fade_level), i);
        end
        press(1'b0, 1'b1, 1'b0);
        chk("fadein_btn_ignored", int'(sel_index), 0);
        pixel_at(100, 50, "lvl8_corner", 'h1666);
        pixel_at(99, 50, "lvl8_left_out", 0);
        pixel_at(900, 50, "lvl8_right_out", 0);
        pixel_at(500, 200, "lvl8_bar", 'h1227);
        for (int i = 9; i <= 16; i++) begin
            do_tick();
            chk("fadein_level", int'(fade_level), i);
        end
        do_tick();
        chk("saturate_max", int'(fade_level), 16);
        pixel_at(500, 300, "full_bg", 'h1DDD);

        // Two-cycle latency from coordinates to pixel.
        pixel_at(99, 50, "lat_pre", 0);
        hcount = 11'd100;
        cycle();
        chk("lat_1cyc", int'(menu_pixel), 0);
        cycle();
        chk("lat_2cyc", int'(menu_pixel), 'h1DDD);

        // Selection wrap and cancellation.
        press(1'b1, 1'b0, 1'b0);
        chk("up_wrap", int'(sel_index), 3);
        press(1'b0, 1'b1, 1'b0);
        chk("down_wrap", int'(sel_index), 0);
        press(1'b1, 1'b1, 1'b0);
        chk("up_down_cancel", int'(sel_index), 0);
        press(1'b0, 1'b1, 1'b0);
        chk("down_to_1", int'(sel_index), 1);

        // Region table with row 1 highlighted at full brightness.
        vecs.push_back('{200, 260, 'h144F, "bar_mid"});
        vecs.push_back('{120, 260, 'h1DDD, "bar_margin"});
        vecs.push_back('{200, 160, 'h1DDD, "row0_bg"});
        vecs.push_back('{150, 250, 'h144F, "bar_top_left"});
        vecs.push_back('{149, 250, 'h1DDD, "bar_left_edge"});
        vecs.push_back('{849, 349, 'h144F, "bar_bot_right"});
        vecs.push_back('{850, 349, 'h1DDD, "bar_right_edge"});
        vecs.push_back('{200, 350, 'h1DDD, "bar_bot_edge"});
        vecs.push_back('{99, 260, 0, "panel_left"});
        vecs.push_back('{900, 300, 0, "panel_right"});
        vecs.push_back('{899, 649, 'h1DDD, "panel_br"});
        vecs.push_back('{500, 650, 0, "panel_bottom"});
        vecs.push_back('{500, 49, 0, "panel_top"});
        vecs.push_back('{100, 50, 'h1DDD, "panel_tl"});
        for (int i = 0; i < vecs.size(); i++)
            pixel_at(vecs[i].h, vecs[i].v, vecs[i].name, vecs[i].exp);

        // Select beats a simultaneous move.
        press(1'b0, 1'b1, 1'b0);
        chk("sel_is_2", int'(sel_index), 2);
        btn_select = 1'b1; btn_down = 1'b1;
        cycle();
        chk("strobe_hi", int'(sel_strobe), 1);
        chk("strobe_sel", int'(sel_index), 2);
        btn_select = 1'b0; btn_down = 1'b0;
        cycle();
        chk("strobe_one_cycle", int'(sel_strobe), 0);
        chk("no_move", int'(sel_index), 2);

        // Hide and re-show keep the selection.
        show = 1'b0;
        repeat (18) do_tick();
        chk("hidden_level", int'(fade_level), 0);
        pixel_at(500, 300, "hidden_pixel", 0);
        press(1'b0, 1'b1, 1'b0);
        chk("hidden_btn", int'(sel_index), 2);
        show = 1'b1;
        do_tick();
        chk("reshow_level", int'(fade_level), 1);
        chk("reshow_sel", int'(sel_index), 2);

        // Fade-in interrupted at level 5.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        show = 1'b1;
        repeat (5) do_tick();
        chk("lvl5", int'(fade_level), 5);
        show = 1'b0;
        for (int k = 0; k < 6; k++) begin
            do_tick();
            chk("fadeout_seq", int'(fade_level), (k == 0) ? 5 : 5 - k);
        end
        do_tick();
        chk("stay_hidden", int'(fade_level), 0);
        pixel_at(300, 300, "fadeout_dark", 0);

        // Asynchronous reset mid-fade.
        show = 1'b1;
        repeat (10) do_tick();
        pixel_at(500, 300, "pre_async", model_pixel(500, 300, 0, 10));
        @(posedge clk65);
        #3;
        reset = 1'b1;
        #1;
        chk("async_level", int'(fade_level), 0);
        chk("async_pixel", int'(menu_pixel), 0);
        cycle();
        reset = 1'b0;
        cycle();

        // Randomised traffic against the reference model.
        show = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            frame_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) show = ~show;
            btn_up     = ($urandom_range(0, 5) == 0);
            btn_down   = ($urandom_range(0, 5) == 0);
            btn_select = ($urandom_range(0, 9) == 0);
            cycle();
            if (it % 40 == 0) begin
                int h, v;
                frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 700);
                pixel_at(h, v, "rand_pixel", model_pixel(h, v, m_sel, m_level));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
